// File: rtl/gcd_host_if.sv
// gcd_host_if: valid/ready front end that serially loads a GCD core and returns its result.
// Optional WAIT-state timeout is built only when GCD_HOST_TIMEOUT_EN is defined.
module gcd_host_if #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             busy
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] b_q;
    logic             armed_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_gcd_q;
    logic             core_start_q;
    logic [WIDTH-1:0] core_data_q;
    logic             done_ok;
    logic             expired;

    // A done seen before any low sample in WAIT is stale from the previous operation.
    assign done_ok = armed_q && core_done;

`ifdef GCD_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          rsp_err_q;
    assign expired = cnt_q == CW'(TIMEOUT - 1);
    assign rsp_err = rsp_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= state_q == S_LOAD_B ? '0 : state_q == S_WAIT ? cnt_q + 1'b1 : cnt_q;
            rsp_err_q <= state_q == S_IDLE ? 1'b0 : state_q == S_WAIT && !done_ok && expired ? 1'b1 : rsp_err_q;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expired = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            b_q          <= '0;
            armed_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_gcd_q    <= '0;
            core_start_q <= 1'b0;
            core_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    b_q <= req_b;
                    // A zero operand would hang a subtractive core, so answer locally.
                    if (req_a == '0 || req_b == '0) begin
                        rsp_gcd_q   <= req_a | req_b;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        core_start_q <= 1'b1;
                        core_data_q  <= req_a;
                        state_q      <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    core_data_q <= b_q;
                    state_q     <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    core_start_q <= 1'b0;
                    armed_q      <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    armed_q <= armed_q | ~core_done;
                    if (done_ok || expired) begin
                        rsp_gcd_q   <= done_ok ? core_result : '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign busy       = state_q != S_IDLE;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_gcd    = rsp_gcd_q;
    assign core_start = core_start_q;
    assign core_data  = core_data_q;
endmodule
